// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type and widths for the data memory responder
package dmem_pkg;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with synchronous byte-enable write and combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [DMEM_BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [DMEM_WORD_W-1:0] wdata_i,
    output logic [DMEM_WORD_W-1:0] rdata_o
);

    // Contents survive reset on purpose, so the array has no reset.
    logic [DMEM_WORD_W-1:0] mem_q [DEPTH];

    // Byte-lane write: only lanes with their enable set are touched.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DMEM_BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - req/gnt/rvalid data memory slave; optional wait states via DMEM_WAIT_STATES_EN
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   data_req_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic                   data_err_o,
    input  logic [31:0]            data_addr_i,
    input  logic                   data_we_i,
    input  logic [DMEM_BE_W-1:0]   data_be_i,
    input  logic [DMEM_WORD_W-1:0] data_wdata_i,
    output logic [DMEM_WORD_W-1:0] data_rdata_o
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef DMEM_WAIT_STATES_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int unsigned WAIT_EFF = WAIT_EN ? WAIT_CYCLES : 0;

`ifdef DMEM_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    dmem_state_e            state_q, state_d;
    logic                   gnt;
    logic [31:0]            offset;
    logic                   req_err;
    logic [IDX_W-1:0]       word_idx;
    logic [DMEM_WORD_W-1:0] arr_rdata;
    logic                   arr_we;
    logic                   err_q;
    logic [DMEM_WORD_W-1:0] rdata_q;

    // Range/alignment decode; addresses below the base wrap high and fail the range test.
    always_comb begin
        offset   = data_addr_i - BASE_ADDR;
        req_err  = (offset >= 32'(4 * DEPTH)) || (data_addr_i[1:0] != 2'b00);
        word_idx = offset[IDX_W+1:2];
    end

    // Next-state and grant decode.
    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
`ifdef DMEM_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if (WAIT_EFF == 0) begin
                        gnt     = 1'b1;
                        state_d = RESP;
                    end
`ifdef DMEM_WAIT_STATES_EN
                    else begin
                        cnt_d   = CNT_W'(WAIT_EFF - 1);
                        state_d = WAIT;
                    end
`endif
                end
            end
`ifdef DMEM_WAIT_STATES_EN
            WAIT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant must drop the instant reset rises, even in IDLE with a zero-wait request.
    assign data_gnt_o = gnt & ~rst_i;
    assign arr_we     = data_gnt_o & data_we_i & ~req_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .be_i    (data_be_i),
        .idx_i   (word_idx),
        .wdata_i (data_wdata_i),
        .rdata_o (arr_rdata)
    );

    // FSM state and response capture; read data is the pre-write word seen at the grant edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (data_gnt_o) begin
                err_q   <= req_err;
                rdata_q <= (req_err || data_we_i) ? '0 : arr_rdata;
            end
        end
    end

`ifdef DMEM_WAIT_STATES_EN
    // Wait-state counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Response outputs are forced to zero outside RESP.
    always_comb begin
        data_rvalid_o = (state_q == RESP);
        data_err_o    = data_rvalid_o & err_q;
        data_rdata_o  = data_rvalid_o ? rdata_q : '0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

`ifdef DMEM_WAIT_STATES_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 0;
`endif
    localparam int BUDGET = 10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_responder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_err_o    (data_err_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_rdata_o  (data_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a request (caller is just after a rising edge), wait for grant, then sample the response.
    task automatic access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, output int lat, output logic rv,
                          output logic er, output logic [31:0] rd);
        bit got_gnt = 0;
        data_req_i   = 1'b1;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wdata;
        lat = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk_i);
            if (data_gnt_o) begin
                got_gnt = 1;
                break;
            end
            lat++;
            @(posedge clk_i);
            #1;
        end
        if (!got_gnt) check("gnt_timeout", 32'd1, 32'd0);
        @(posedge clk_i);
        #1;
        data_req_i = 1'b0;
        @(negedge clk_i);
        rv = data_rvalid_o;
        er = data_err_o;
        rd = data_rdata_o;
    endtask

    task automatic xfer(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        logic rv, er;
        logic [31:0] rd;
        step();
        access(addr, we, be, wdata, lat, rv, er, rd);
        check({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        check({tag, "_rvalid"}, {31'd0, rv}, 32'd1);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_rdata"}, rd, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic rv, er;
        logic [31:0] rd;
        bit   seen;

        // Reset with a request already pending: all outputs must stay low.
        rst_i        = 1'b1;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_1002;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
        check("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        check("rst_err", {31'd0, data_err_o}, 32'd0);
        check("rst_rdata", data_rdata_o, 32'd0);

        // Release with request still high: handled as a fresh request from IDLE.
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        access(32'h0000_1002, 1'b0, 4'hF, 32'h0, lat, rv, er, rd);
        check("post_rst_lat", 32'(lat), 32'(EXP_LAT));
        check("post_rst_err", {31'd0, er}, 32'd1);

        // Basic write/read and byte enables.
        xfer("wr_full", 32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
        xfer("rd_full", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);
        xfer("wr_be5", 32'h0000_1000, 1'b1, 4'b0101, 32'h1122_3344, 1'b0, 32'h0);
        xfer("rd_be5", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44);
        xfer("wr_be0", 32'h0000_1000, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h0);
        xfer("rd_be0", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44);

        // Error cases: misaligned, past the end, below the base; none may touch memory.
        xfer("rd_mis", 32'h0000_1002, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0);
        xfer("rd_oor", 32'h0000_1400, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0);
        xfer("rd_low", 32'h0000_0FFC, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0);
        xfer("wr_mis", 32'h0000_1001, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0);
        xfer("wr_oor", 32'h0000_1400, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0);
        xfer("rd_keep", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44);

        // Last word in range.
        xfer("wr_last", 32'h0000_13FC, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0);
        xfer("rd_last", 32'h0000_13FC, 1'b0, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D);

`ifdef DMEM_WAIT_STATES_EN
        // Request withdrawn in WAIT: no grant, no response, back in IDLE.
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_1000;
        data_we_i   = 1'b0;
        @(negedge clk_i);
        check("drop_c0_gnt", {31'd0, data_gnt_o}, 32'd0);
        step();
        data_req_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (data_gnt_o || data_rvalid_o) seen = 1;
        end
        check("drop_quiet", {31'd0, seen}, 32'd0);
        xfer("drop_after", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44);
`else
        // Request held high: grant, response, grant again every other cycle.
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_1000;
        data_we_i   = 1'b0;
        @(negedge clk_i);
        check("b2b_gnt0", {31'd0, data_gnt_o}, 32'd1);
        check("b2b_rv0", {31'd0, data_rvalid_o}, 32'd0);
        step();
        @(negedge clk_i);
        check("b2b_gnt1", {31'd0, data_gnt_o}, 32'd0);
        check("b2b_rv1", {31'd0, data_rvalid_o}, 32'd1);
        check("b2b_rd1", data_rdata_o, 32'hDE22_BE44);
        step();
        @(negedge clk_i);
        check("b2b_gnt2", {31'd0, data_gnt_o}, 32'd1);
        step();
        data_req_i = 1'b0;
        @(negedge clk_i);
        check("b2b_rv3", {31'd0, data_rvalid_o}, 32'd1);
        step();
        @(negedge clk_i);
        check("idle_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        check("idle_err", {31'd0, data_err_o}, 32'd0);
        check("idle_rdata", data_rdata_o, 32'd0);
`endif

        // Reset during the RESP cycle of a write: response killed, write already committed.
        step();
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_1004;
        data_we_i    = 1'b1;
        data_be_i    = 4'hF;
        data_wdata_i = 32'hAABB_CCDD;
        seen = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk_i);
            if (data_gnt_o) begin
                seen = 1;
                break;
            end
        end
        check("rr_gnt", {31'd0, seen}, 32'd1);
        step();
        check("rr_resp", {31'd0, data_rvalid_o}, 32'd1);
        rst_i      = 1'b1;
        data_req_i = 1'b0;
        #1;
        check("rr_rv_kill", {31'd0, data_rvalid_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (data_rvalid_o) seen = 1;
        end
        check("rr_no_resp", {31'd0, seen}, 32'd0);
        xfer("rr_rd", 32'h0000_1004, 1'b0, 4'hF, 32'h0, 1'b0, 32'hAABB_CCDD);
        xfer("rr_rd0", 32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
